string_hw_avalon_ctrl: RTL and testbench
========================================

# string_hw_avalon_ctrl

Avalon-MM slave front-end that sits directly upstream of the string accelerator engine. It holds the operands (A, B, lengths, operation index) in software-visible registers and drives the engine's go/done handshake. It captures the engine result and exposes it, together with status flags and an optional interrupt, to the Nios II.

## Interface
- TIMEOUT_CYCLES, 64: number of cycles allowed in ISSUE without `eng_done` before the operation is aborted; must be ≥ 8.
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low (0 = reset asserted); release is synchronised externally.
- avs_chipselect  in  1  slave select; read and write are ignored when this is 0.
- avs_address  in  2  register select: 0 = A, 1 = B, 2 = CTRL, 3 = STATUS.
- avs_write  in  1  write strobe; one register write per cycle.
- avs_writedata  in  32  write data.
- avs_read  in  1  read strobe.
- avs_readdata  out  32  registered read data; read latency is 1 cycle.
- irq  out  1  level interrupt to the CPU.
- eng_go  out  1  go to the engine; level, held until the handshake completes.
- eng_index  out  3  operation: 0 = compare, 1 = to-upper, 2 = to-lower.
- eng_A, eng_B  out  16  operand strings; bits [15:8] hold char 0 and bits [7:0] hold char 1.
- eng_lengthA, eng_lengthB  out  2  operand lengths, 0..2.
- eng_done  in  1  engine done level.
- eng_result  in  16  engine result; valid while `eng_done`=1.

## Operation
- Registers (all zero after reset):
  - A, B: bits [15:0] stored. Bits [31:16] are ignored on write and read as 0.
  - CTRL write: [2:0] index, [5:4] lengthA, [7:6] lengthB, [8] start (self-clearing), [9] irq_en. CTRL read returns the stored fields with start = 0.
  - STATUS read: [15:0] result, [16] busy, [17] done, [18] err_timeout, [19] err_index, all other bits 0. Any write to STATUS clears done, err_timeout and err_index.
- While busy=1, writes to A, B and CTRL are ignored entirely, including start and irq_en. STATUS writes are still accepted.
- Start with index > 2: no engine access. err_index sets and done stays 0 on the next edge; the FSM stays in IDLE.
- FSM states:
  - IDLE: eng_go=0, busy=0. A start with a valid index clears done and both error flags, clears the timeout counter, and moves to ISSUE.
  - ISSUE: eng_go=1, busy=1, counter increments each cycle.
    - On `eng_done`=1: latch `eng_result` into result and go to RELEASE.
    - Else, when counter = TIMEOUT_CYCLES−1: set err_timeout, leave result unchanged, go to IDLE; eng_go drops on that edge.
  - RELEASE: eng_go=0, busy=1. On `eng_done`=0: set done and go to IDLE. There is no timeout in this state.
- eng_A, eng_B, eng_index and the lengths are driven straight from the registers. They are stable throughout busy because register writes are locked.
- Flag set/clear priority: a set event in the same cycle as a STATUS clear write wins, so the flag ends up 1.
- irq (registered) = irq_en & (done | err_timeout | err_index). It falls on the edge after a clear write or an irq_en=0 write.
- Reset, including mid-operation: all registers, flags, eng_go, irq and avs_readdata go to 0 immediately, and the FSM goes to IDLE.

## Timing
- Start written at edge N: eng_go=1 and busy=1 are visible after edge N; busy reads as 1 from a read issued at cycle N+1.
- `eng_done` sampled high at edge M: result latched at edge M and eng_go=0 after edge M.
  - `eng_done` sampled low at edge K > M: done=1 after edge K, irq=1 after edge K+1.
- A read at edge R returns data reflecting register state before edge R, presented after edge R.
- With a 1-cycle-per-state engine, a to-upper of length 2 completes in fewer than 12 cycles from the start write to done.

## Test plan
- A=0x6162 ("ab"), lengthA=2, index=1, start → eng_go rises and is held until eng_done; STATUS then reads result 0x4142, done=1, busy=0, errors 0.
- A=B=0x4869, index=0, irq_en=1, start → result 0x0001, done=1, irq=1; a STATUS write then drops irq on the next edge and done reads 0.
- CTRL with index=3 and start → eng_go never asserts; STATUS reads err_index=1, busy=0, done=0.
- Engine model holds eng_done=0, TIMEOUT_CYCLES=64, start → eng_go deasserts exactly 64 cycles after it rises; err_timeout=1 and result keeps its previous value.
- While busy, write A=0xFFFF and CTRL start → eng_A unchanged, no second operation launched; STATUS clear written in the same cycle done sets → done reads 1.
- Reset pulled low mid-ISSUE → eng_go, irq, busy and all registers read 0 after release; a new start then completes normally.

Source files
------------

// File: rtl/string_hw_avalon_ctrl.sv
// Avalon-MM register front-end for the string accelerator engine.
// Holds operands and control fields, runs the go/done handshake with a
// timeout, captures the engine result and raises a level interrupt.
module string_hw_avalon_ctrl #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        avs_chipselect,
  input  logic [1:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic        irq,
  output logic        eng_go,
  output logic [2:0]  eng_index,
  output logic [15:0] eng_A,
  output logic [15:0] eng_B,
  output logic [1:0]  eng_lengthA,
  output logic [1:0]  eng_lengthB,
  input  logic        eng_done,
  input  logic [15:0] eng_result
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      a_q;
  logic [15:0]      b_q;
  logic [2:0]       index_q;
  logic [1:0]       lena_q;
  logic [1:0]       lenb_q;
  logic             irqen_q;
  logic [15:0]      result_q;
  logic             done_q;
  logic             errt_q;
  logic             erri_q;
  logic [31:0]      rd_mux;

  logic busy;
  logic wr_en;
  logic wr_open;
  logic wr_a;
  logic wr_b;
  logic wr_ctrl;
  logic wr_stat;
  logic start_req;
  logic idx_ok;
  logic start_ok;
  logic start_bad;
  logic set_done;
  logic set_tmo;
  logic flag_clr;
  logic unused_ok;

  // Register writes are locked out while an operation is in flight so the
  // operands presented to the engine cannot change under it.
  assign busy      = (state != IDLE);
  assign wr_en     = avs_chipselect & avs_write;
  assign wr_open   = wr_en & ~busy;
  assign wr_a      = wr_open & (avs_address == 2'd0);
  assign wr_b      = wr_open & (avs_address == 2'd1);
  assign wr_ctrl   = wr_open & (avs_address == 2'd2);
  assign wr_stat   = wr_en & (avs_address == 2'd3);
  assign start_req = wr_ctrl & avs_writedata[8];
  assign idx_ok    = (avs_writedata[2:0] <= 3'd2);
  assign start_ok  = start_req & idx_ok;
  assign start_bad = start_req & ~idx_ok;
  assign set_done  = (state == RELEASE) & ~eng_done;
  assign set_tmo   = (state == ISSUE) & ~eng_done & (cnt == CNT_LAST);
  assign flag_clr  = wr_stat | start_ok;
  assign unused_ok = &{1'b0, avs_writedata[31:16]};

  assign eng_A       = a_q;
  assign eng_B       = b_q;
  assign eng_index   = index_q;
  assign eng_lengthA = lena_q;
  assign eng_lengthB = lenb_q;

  // Software-visible operand and control registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q     <= '0;
      b_q     <= '0;
      index_q <= '0;
      lena_q  <= '0;
      lenb_q  <= '0;
      irqen_q <= 1'b0;
    end else begin
      if (wr_a) a_q <= avs_writedata[15:0];
      if (wr_b) b_q <= avs_writedata[15:0];
      if (wr_ctrl) begin
        index_q <= avs_writedata[2:0];
        lena_q  <= avs_writedata[5:4];
        lenb_q  <= avs_writedata[7:6];
        irqen_q <= avs_writedata[9];
      end
    end
  end

  // Handshake FSM: raise go, wait for done (or time out), wait for done to drop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      eng_go   <= 1'b0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            state  <= ISSUE;
            cnt    <= '0;
            eng_go <= 1'b1;
          end
        end
        ISSUE: begin
          if (eng_done) begin
            result_q <= eng_result;
            state    <= RELEASE;
            eng_go   <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state  <= IDLE;
            eng_go <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (!eng_done) state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          eng_go <= 1'b0;
        end
      endcase
    end
  end

  // Sticky status flags (set beats clear) and the registered interrupt
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q <= 1'b0;
      errt_q <= 1'b0;
      erri_q <= 1'b0;
      irq    <= 1'b0;
    end else begin
      done_q <= set_done  | (done_q & ~flag_clr);
      errt_q <= set_tmo   | (errt_q & ~flag_clr);
      erri_q <= start_bad | (erri_q & ~flag_clr);
      irq    <= irqen_q & (done_q | errt_q | erri_q);
    end
  end

  // Read mux; start always reads back as 0
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      2'd0: rd_mux[15:0] = a_q;
      2'd1: rd_mux[15:0] = b_q;
      2'd2: rd_mux[9:0]  = {irqen_q, 1'b0, lenb_q, lena_q, 1'b0, index_q};
      default: rd_mux[19:0] = {erri_q, errt_q, done_q, busy, result_q};
    endcase
  end

  // One-cycle registered read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      avs_readdata <= '0;
    end else if (avs_chipselect & avs_read) begin
      avs_readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_string_hw_avalon_ctrl.sv
// Bench for string_hw_avalon_ctrl: directed scenarios plus randomized
// operations against a behavioural model, with an engine responder model.
module tb_string_hw_avalon_ctrl;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        avs_chipselect = 1'b0;
  logic [1:0]  avs_address = 2'd0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = 32'd0;
  logic        avs_read = 1'b0;
  logic [31:0] avs_readdata;
  logic        irq;
  logic        eng_go;
  logic [2:0]  eng_index;
  logic [15:0] eng_A;
  logic [15:0] eng_B;
  logic [1:0]  eng_lengthA;
  logic [1:0]  eng_lengthB;
  logic        eng_done;
  logic [15:0] eng_result;

  // engine responder
  logic        eng_manual = 1'b0;
  logic        done_man = 1'b0;
  logic [15:0] res_man = 16'd0;
  logic        done_auto = 1'b0;
  logic [15:0] res_auto = 16'd0;
  int          e_cnt = 0;
  int          lat = 1;
  int          rel = 1;

  assign eng_done   = eng_manual ? done_man : done_auto;
  assign eng_result = eng_manual ? res_man : res_auto;

  int n_chk = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  string_hw_avalon_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .avs_chipselect(avs_chipselect), .avs_address(avs_address),
    .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_read(avs_read), .avs_readdata(avs_readdata),
    .irq(irq), .eng_go(eng_go), .eng_index(eng_index),
    .eng_A(eng_A), .eng_B(eng_B),
    .eng_lengthA(eng_lengthA), .eng_lengthB(eng_lengthB),
    .eng_done(eng_done), .eng_result(eng_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // what the engine would compute for an operation
  function automatic logic [15:0] eng_fn(input logic [2:0] idx, input logic [15:0] a,
                                         input logic [15:0] b, input logic [1:0] la,
                                         input logic [1:0] lb);
    logic [15:0] r;
    logic [7:0]  ch;
    r = 16'd0;
    if (idx == 3'd0) begin
      r[0] = (la == lb) && (la < 2'd1 || a[15:8] == b[15:8]) && (la < 2'd2 || a[7:0] == b[7:0]);
    end else if (idx == 3'd1 || idx == 3'd2) begin
      for (int i = 0; i < 2; i++) begin
        if (i < int'(la)) begin
          ch = (i == 0) ? a[15:8] : a[7:0];
          if (idx == 3'd1 && ch >= 8'h61 && ch <= 8'h7a) ch = ch - 8'd32;
          if (idx == 3'd2 && ch >= 8'h41 && ch <= 8'h5a) ch = ch + 8'd32;
          if (i == 0) r[15:8] = ch;
          else r[7:0] = ch;
        end
      end
    end else begin
      r = 16'hFFFF;
    end
    return r;
  endfunction

  // engine responder: done after 'lat' go cycles, drops 'rel' cycles after go falls
  always @(negedge clk) begin
    if (!reset || eng_manual) begin
      done_auto = 1'b0;
      e_cnt = 0;
    end else if (eng_go && !done_auto) begin
      e_cnt++;
      if (e_cnt >= lat) begin
        done_auto = 1'b1;
        res_auto = eng_fn(eng_index, eng_A, eng_B, eng_lengthA, eng_lengthB);
        e_cnt = 0;
      end
    end else if (!eng_go && done_auto) begin
      e_cnt++;
      if (e_cnt >= rel) begin
        done_auto = 1'b0;
        e_cnt = 0;
      end
    end else if (!eng_go) begin
      e_cnt = 0;
    end
  end

  // behavioural model of the register file and operation lifecycle
  logic [15:0] m_a = 0, m_b = 0, m_result = 0;
  logic [2:0]  m_idx = 0;
  logic [1:0]  m_la = 0, m_lb = 0;
  logic        m_irqen = 0, m_done = 0, m_tmo = 0, m_ierr = 0, m_irq = 0, m_go = 0;
  logic [31:0] m_rdata = 0;
  int          m_phase = 0;   // 0 idle, 1 waiting for engine, 2 waiting for done to drop
  int          m_age = 0;
  int          p_phase;
  logic        p_busy, p_flags, clr, s_done, s_tmo, s_idx, launch;

  function automatic logic [31:0] reg_view(input logic [1:0] a);
    case (a)
      2'd0: return {16'd0, m_a};
      2'd1: return {16'd0, m_b};
      2'd2: return {22'd0, m_irqen, 1'b0, m_lb, m_la, 1'b0, m_idx};
      default: return {12'd0, m_ierr, m_tmo, m_done, (m_phase != 0), m_result};
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_a = 0; m_b = 0; m_result = 0; m_idx = 0; m_la = 0; m_lb = 0;
      m_irqen = 0; m_done = 0; m_tmo = 0; m_ierr = 0; m_irq = 0; m_go = 0;
      m_rdata = 0; m_phase = 0; m_age = 0;
    end else begin
      p_phase = m_phase;
      p_busy  = (m_phase != 0);
      p_flags = m_done | m_tmo | m_ierr;
      if (avs_chipselect && avs_read) m_rdata = reg_view(avs_address);
      clr = avs_chipselect && avs_write && avs_address == 2'd3;
      s_done = 0; s_tmo = 0; s_idx = 0; launch = 0;
      m_irq = m_irqen & p_flags;
      if (avs_chipselect && avs_write && !p_busy) begin
        if (avs_address == 2'd0) m_a = avs_writedata[15:0];
        if (avs_address == 2'd1) m_b = avs_writedata[15:0];
        if (avs_address == 2'd2) begin
          m_idx = avs_writedata[2:0];
          m_la = avs_writedata[5:4];
          m_lb = avs_writedata[7:6];
          m_irqen = avs_writedata[9];
          if (avs_writedata[8]) begin
            if (avs_writedata[2:0] > 3'd2) s_idx = 1;
            else begin clr = 1; launch = 1; end
          end
        end
      end
      if (p_phase == 0 && launch) begin
        m_phase = 1; m_age = 0; m_go = 1;
      end else if (p_phase == 1) begin
        if (eng_done) begin
          m_result = eng_result; m_phase = 2; m_go = 0;
        end else if (m_age == TO - 1) begin
          s_tmo = 1; m_phase = 0; m_go = 0;
        end else begin
          m_age++;
        end
      end else if (p_phase == 2 && !eng_done) begin
        s_done = 1; m_phase = 0;
      end
      m_done = s_done ? 1'b1 : (clr ? 1'b0 : m_done);
      m_tmo  = s_tmo  ? 1'b1 : (clr ? 1'b0 : m_tmo);
      m_ierr = s_idx  ? 1'b1 : (clr ? 1'b0 : m_ierr);
    end
  end

  // per-cycle comparison of all outputs against the model
  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      check("readdata", avs_readdata, m_rdata);
      check("eng_go", {31'd0, eng_go}, {31'd0, m_go});
      check("irq", {31'd0, irq}, {31'd0, m_irq});
      check("eng_A", {16'd0, eng_A}, {16'd0, m_a});
      check("eng_B", {16'd0, eng_B}, {16'd0, m_b});
      check("eng_ctl", {25'd0, eng_index, eng_lengthA, eng_lengthB},
            {25'd0, m_idx, m_la, m_lb});
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    avs_chipselect = 1; avs_write = 1; avs_address = a; avs_writedata = d;
    @(negedge clk);
    avs_chipselect = 0; avs_write = 0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    avs_chipselect = 1; avs_read = 1; avs_address = a;
    @(negedge clk);
    avs_chipselect = 0; avs_read = 0;
    d = avs_readdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input int max);
    int k;
    k = 0;
    while ((m_phase != 0 || eng_done) && k < max) begin
      @(negedge clk);
      k++;
    end
    if (k >= max) check("wait_idle_bound", 32'd1, 32'd0);
  endtask

  logic [31:0] d;
  int          n_go;
  int          r;
  logic [15:0] ra, rb;

  initial begin
    idle(3);
    check("reset_readdata", avs_readdata, 32'd0);
    check("reset_go_irq", {30'd0, eng_go, irq}, 32'd0);
    reset = 1;
    chk_en = 1;
    idle(1);

    // to-upper "ab"
    lat = 1; rel = 1;
    wr(2'd0, 32'hDEAD_6162);
    wr(2'd2, 32'h0000_0121);
    check("t1_go_rise", {31'd0, eng_go}, 32'd1);
    wait_idle(50);
    rd(2'd3, d);
    check("t1_status", d, 32'h0002_4142);
    rd(2'd0, d);
    check("t1_a_upper_zero", d, 32'h0000_6162);

    // compare equal with interrupt
    lat = 3; rel = 2;
    wr(2'd0, 32'h0000_4869);
    wr(2'd1, 32'h0000_4869);
    wr(2'd2, 32'h0000_03A0);
    wait_idle(50);
    idle(1);
    check("t2_irq_set", {31'd0, irq}, 32'd1);
    rd(2'd3, d);
    check("t2_status", d, 32'h0002_0001);
    wr(2'd3, 32'd0);
    idle(1);
    check("t2_irq_clear", {31'd0, irq}, 32'd0);
    rd(2'd3, d);
    check("t2_status_clr", d, 32'h0000_0001);

    // invalid index
    wr(2'd2, 32'h0000_0103);
    idle(3);
    check("t3_no_go", {31'd0, eng_go}, 32'd0);
    rd(2'd3, d);
    check("t3_status", d, 32'h0008_0001);
    rd(2'd2, d);
    check("t3_ctrl", d, 32'h0000_0003);

    // writes locked while busy; done set coincides with clear write
    eng_manual = 1; done_man = 0;
    wr(2'd0, 32'h0000_6162);
    wr(2'd2, 32'h0000_0121);
    wr(2'd0, 32'h0000_FFFF);
    wr(2'd2, 32'h0000_0301);
    check("t4_a_locked", {16'd0, eng_A}, 32'h0000_6162);
    done_man = 1; res_man = 16'h1234;
    idle(1);
    done_man = 0;
    wr(2'd3, 32'd0);
    rd(2'd3, d);
    check("t4_status", d, 32'h0002_1234);
    rd(2'd2, d);
    check("t4_ctrl", d, 32'h0000_0021);

    // timeout
    wr(2'd2, 32'h0000_0121);
    n_go = 0;
    for (int i = 0; i < 100 && eng_go; i++) begin
      n_go++;
      @(negedge clk);
    end
    check("t5_go_cycles", n_go, 32'd64);
    rd(2'd3, d);
    check("t5_status", d, 32'h0004_1234);

    // reset mid-operation, then a normal operation
    wr(2'd2, 32'h0000_0121);
    idle(5);
    reset = 0;
    idle(2);
    reset = 1;
    eng_manual = 0;
    idle(1);
    check("t6_go", {31'd0, eng_go}, 32'd0);
    check("t6_irq", {31'd0, irq}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), d);
      check("t6_reg_zero", d, 32'd0);
    end
    wr(2'd0, 32'h0000_7A41);
    wr(2'd2, 32'h0000_0122);
    wait_idle(50);
    rd(2'd3, d);
    check("t6_status", d, 32'h0002_7A61);

    // randomized operations
    for (int op = 0; op < 40; op++) begin
      ra = {8'(8'h41 + $urandom_range(0, 57)), 8'(8'h41 + $urandom_range(0, 57))};
      rb = ($urandom_range(0, 9) < 3) ? ra :
           {8'(8'h41 + $urandom_range(0, 57)), 8'(8'h41 + $urandom_range(0, 57))};
      lat = ($urandom_range(0, 11) == 0) ? 80 : $urandom_range(1, 5);
      rel = $urandom_range(0, 3);
      wr(2'd0, {$urandom, ra} & 32'hFFFF_FFFF);
      wr(2'd1, {16'h0, rb});
      r = ($urandom_range(0, 9) == 0) ? $urandom_range(3, 7) : $urandom_range(0, 2);
      wr(2'd2, {22'd0, 1'($urandom_range(0, 1)), 1'b1, 2'($urandom_range(0, 2)),
                2'($urandom_range(0, 2)), 1'b0, 3'(r)});
      for (int k = 0; k < 150 && (m_phase != 0 || eng_done); k++) begin
        r = $urandom_range(0, 9);
        if (r < 3) rd(2'($urandom_range(0, 3)), d);
        else if (r == 3) wr(2'($urandom_range(0, 3)), $urandom & 32'hFFFF_FEFF);
        else idle(1);
      end
      wait_idle(100);
      rd(2'd3, d);
      if ($urandom_range(0, 1) == 1) wr(2'd3, 32'd0);
    end

    idle(2);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
